uart_32_bit_tx_arbiter: RTL



---
 rtl/uart_32_bit_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_32_bit_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_32_bit_pkg.sv
// Shared definitions for the 32-bit UART slice: payload width and the
// TX arbiter state encoding.
package uart_32_bit_pkg;

    localparam int UART_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning upward
// from last_i+1, wrapping modulo N.
module uart_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         grant_onehot_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 any_o
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        int idx;
        idx            = 0;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_o          = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_i) + i) % N;
            if (!any_o && req_i[idx]) begin
                any_o               = 1'b1;
                grant_idx_o         = IDX_W'(idx);
                grant_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_32_bit_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NUM_REQ requesters.
// Optional watchdog on the TX frame enabled by defining UART_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | req_ready offered to the round-robin winner; accept latches word
// LAUNCH    | one-cycle tx_start to the TX core
// WAIT_DONE | frame in flight; waits for tx_done (or watchdog expiry)
module uart_32_bit_tx_arbiter
    import uart_32_bit_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         tx_start_o,
    output logic [DATA_W-1:0]            tx_data_o,
    input  logic                         tx_done_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         busy_o,
    output logic                         timeout_err_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE   = ARB_IDLE;
    localparam logic [1:0] S_LAUNCH = ARB_LAUNCH;
    localparam logic [1:0] S_WAIT   = ARB_WAIT_DONE;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tx_start_q;
    logic              busy_q;
    logic              terr_q, terr_d;
    logic              wd_expire;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    uart_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i          (req_valid_i),
        .last_i         (last_q),
        .grant_onehot_o (pick_onehot),
        .grant_idx_o    (pick_idx),
        .any_o          (pick_any)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    // Counter is 0 in the first WAIT_DONE cycle; expiry is flagged on the
    // last waiting cycle so the error pulse lands TIMEOUT_CYCLES after entry.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_LAUNCH) begin
            wd_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expire = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    data_d  = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_i) begin
                    state_d = S_IDLE;
                end else if (wd_expire) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= ID_W'(NUM_REQ - 1);
            grant_q    <= '0;
            data_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            tx_start_q <= (state_d == S_LAUNCH);
            busy_q     <= (state_d != S_IDLE);
            terr_q     <= terr_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE && !rst) ? pick_onehot : '0;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = data_q;
    assign grant_id_o    = grant_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;

endmodule
